// File: rtl/neuron_train_sequencer_if.sv
// Token and completion handshakes between the sequencer, its upstream streams and the Neuron.
// Latency: none (wires only).
// Backpressure: carried by the Ready signals; master modport is the sequencer side.
interface neuron_train_sequencer_if;
    logic iValid_AM_Fwd;
    logic oReady_AM_Fwd;
    logic oValid_BM_Fwd;
    logic iReady_BM_Fwd;
    logic iValid_AM_Bwd;
    logic oReady_AM_Bwd;
    logic oValid_BM_Bwd;
    logic iReady_BM_Bwd;
    logic iValid_Cmp;
    logic iReady_Cmp;

    modport master (
        input  iValid_AM_Fwd, iReady_BM_Fwd,
        input  iValid_AM_Bwd, iReady_BM_Bwd,
        input  iValid_Cmp, iReady_Cmp,
        output oReady_AM_Fwd, oValid_BM_Fwd,
        output oReady_AM_Bwd, oValid_BM_Bwd
    );

    modport slave (
        output iValid_AM_Fwd, iReady_BM_Fwd,
        output iValid_AM_Bwd, iReady_BM_Bwd,
        output iValid_Cmp, iReady_Cmp,
        input  oReady_AM_Fwd, oValid_BM_Fwd,
        input  oReady_AM_Bwd, oValid_BM_Bwd
    );
endinterface

// File: rtl/neuron_train_sequencer.sv
// Sequences one Neuron layer: one fwd then one bwd token per sample, weight-update strobe per mini-batch.
// Latency: 4 cycles/training sample (+1 at batch boundary), 2 cycles/inference sample, no stalls.
// Backpressure: token gates pass Valid/Ready straight through; WAIT states hold until completion.
// Optional SEQ_TIMEOUT_EN: wait-state watchdog that raises sticky oError and aborts to IDLE.
module neuron_train_sequencer #(
    parameter int NB      = 4,
    parameter int NS      = 16,
    parameter int TIMEOUT = 255,
    localparam int SW     = (NS > 1) ? $clog2(NS) : 1,
    localparam int BW     = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic                         iCLK,
    input  logic                         iRST,
    input  logic                         iStart,
    input  logic                         iTrain,
    output logic                         oBusy,
    output logic                         oDone,
    output logic                         oMode,
    output logic                         oUpdate,
    output logic [SW-1:0]                oSample,
    output logic                         oError,
    neuron_train_sequencer_if.master     bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FWD      = 3'd1,
        FWD_WAIT = 3'd2,
        BWD      = 3'd3,
        BWD_WAIT = 3'd4,
        UPDATE   = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SW-1:0]   r_sample;
    logic [SW-1:0]   w_sample_nxt;
    logic [BW-1:0]   r_batch;
    logic [BW-1:0]   w_batch_nxt;
    logic            r_train;
    logic            w_train_nxt;
    logic            r_mode;
    logic            r_update;
    logic            r_done;

    logic            w_fwd_hs;
    logic            w_bwd_hs;
    logic            w_cmp;
    logic            w_last_sample;
    logic            w_last_batch;

    assign w_fwd_hs      = bus.iValid_AM_Fwd & bus.iReady_BM_Fwd;
    assign w_bwd_hs      = bus.iValid_AM_Bwd & bus.iReady_BM_Bwd;
    assign w_cmp         = bus.iValid_Cmp & bus.iReady_Cmp;
    assign w_last_sample = (r_sample == SW'(NS - 1));
    assign w_last_batch  = (r_batch == BW'(NB - 1));

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TW-1:0]   r_tmo;
    logic            r_error;
    logic            w_tmo_hit;
    logic            w_err_set;
    logic            w_wait_entry;

    assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));
`endif

    // Next-state, counter and epoch-mode decisions
    always_comb begin
        w_state_nxt  = r_state;
        w_sample_nxt = r_sample;
        w_batch_nxt  = r_batch;
        w_train_nxt  = r_train;
`ifdef SEQ_TIMEOUT_EN
        w_err_set    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (iStart) begin
                    w_sample_nxt = '0;
                    w_batch_nxt  = '0;
                    w_train_nxt  = iTrain;
                    w_state_nxt  = FWD;
                end
            end
            FWD: begin
                if (w_fwd_hs) w_state_nxt = FWD_WAIT;
            end
            FWD_WAIT: begin
                if (w_cmp) begin
                    if (r_train) begin
                        w_state_nxt = BWD;
                    end else if (w_last_sample) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_sample_nxt = r_sample + 1'b1;
                        w_state_nxt  = FWD;
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = IDLE;
                end
`endif
            end
            BWD: begin
                if (w_bwd_hs) w_state_nxt = BWD_WAIT;
            end
            BWD_WAIT: begin
                if (w_cmp) begin
                    if (w_last_batch || w_last_sample) begin
                        w_state_nxt = UPDATE;
                    end else begin
                        w_sample_nxt = r_sample + 1'b1;
                        w_batch_nxt  = r_batch + 1'b1;
                        w_state_nxt  = FWD;
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = IDLE;
                end
`endif
            end
            UPDATE: begin
                w_batch_nxt = '0;
                if (w_last_sample) begin
                    w_state_nxt = DONE;
                end else begin
                    w_sample_nxt = r_sample + 1'b1;
                    w_state_nxt  = FWD;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and registered strobes; strobes are decoded from the next state
    // so they line up exactly with residence in BWD*/UPDATE/DONE
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_state  <= IDLE;
            r_sample <= '0;
            r_batch  <= '0;
            r_train  <= 1'b0;
            r_mode   <= 1'b0;
            r_update <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sample <= w_sample_nxt;
            r_batch  <= w_batch_nxt;
            r_train  <= w_train_nxt;
            r_mode   <= (w_state_nxt == BWD) || (w_state_nxt == BWD_WAIT);
            r_update <= (w_state_nxt == UPDATE);
            r_done   <= (w_state_nxt == DONE);
        end
    end

`ifdef SEQ_TIMEOUT_EN
    assign w_wait_entry = ((w_state_nxt == FWD_WAIT) && (r_state != FWD_WAIT)) ||
                          ((w_state_nxt == BWD_WAIT) && (r_state != BWD_WAIT));

    // Watchdog: restart on entering a wait state, count every cycle spent waiting
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_tmo <= '0;
        end else if (w_wait_entry) begin
            r_tmo <= '0;
        end else if ((r_state == FWD_WAIT) || (r_state == BWD_WAIT)) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_error <= 1'b0;
        end else if (w_err_set) begin
            r_error <= 1'b1;
        end
    end

    assign oError = r_error;
`else
    assign oError = 1'b0;
`endif

    assign oBusy   = (r_state != IDLE);
    assign oDone   = r_done;
    assign oMode   = r_mode;
    assign oUpdate = r_update;
    assign oSample = r_sample;

    // Token gates: transparent only in their admit state, closed everywhere else
    assign bus.oValid_BM_Fwd = (r_state == FWD) & bus.iValid_AM_Fwd;
    assign bus.oReady_AM_Fwd = (r_state == FWD) & bus.iReady_BM_Fwd;
    assign bus.oValid_BM_Bwd = (r_state == BWD) & bus.iValid_AM_Bwd;
    assign bus.oReady_AM_Bwd = (r_state == BWD) & bus.iReady_BM_Bwd;

endmodule

// File: tb/tb_neuron_train_sequencer.sv
// Directed bench: two sequencers (NB=2/NS=4 and NB=3/NS=4, TIMEOUT=8) driven one at a time.
// A small responder raises completion 3 cycles after each token handshake.
module tb_neuron_train_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       start [2];
    logic       train [2];
    logic       vfwd  [2];
    logic       rbfwd [2];
    logic       vbwd  [2];
    logic       rbbwd [2];
    logic       vcmp  [2];
    logic       rcmp  [2];
    logic       busy  [2];
    logic       done  [2];
    logic       mode  [2];
    logic       upd   [2];
    logic       err   [2];
    logic [1:0] samp  [2];
    logic       ovf   [2];
    logic       oraf  [2];
    logic       ovb   [2];
    logic       orab  [2];

    neuron_train_sequencer_if ifc0 ();
    neuron_train_sequencer_if ifc1 ();

    assign ifc0.iValid_AM_Fwd = vfwd[0];
    assign ifc0.iReady_BM_Fwd = rbfwd[0];
    assign ifc0.iValid_AM_Bwd = vbwd[0];
    assign ifc0.iReady_BM_Bwd = rbbwd[0];
    assign ifc0.iValid_Cmp    = vcmp[0];
    assign ifc0.iReady_Cmp    = rcmp[0];
    assign ovf[0]  = ifc0.oValid_BM_Fwd;
    assign oraf[0] = ifc0.oReady_AM_Fwd;
    assign ovb[0]  = ifc0.oValid_BM_Bwd;
    assign orab[0] = ifc0.oReady_AM_Bwd;

    assign ifc1.iValid_AM_Fwd = vfwd[1];
    assign ifc1.iReady_BM_Fwd = rbfwd[1];
    assign ifc1.iValid_AM_Bwd = vbwd[1];
    assign ifc1.iReady_BM_Bwd = rbbwd[1];
    assign ifc1.iValid_Cmp    = vcmp[1];
    assign ifc1.iReady_Cmp    = rcmp[1];
    assign ovf[1]  = ifc1.oValid_BM_Fwd;
    assign oraf[1] = ifc1.oReady_AM_Fwd;
    assign ovb[1]  = ifc1.oValid_BM_Bwd;
    assign orab[1] = ifc1.oReady_AM_Bwd;

    neuron_train_sequencer #(.NB(2), .NS(4), .TIMEOUT(8)) dut0 (
        .iCLK(clk), .iRST(rst), .iStart(start[0]), .iTrain(train[0]),
        .oBusy(busy[0]), .oDone(done[0]), .oMode(mode[0]), .oUpdate(upd[0]),
        .oSample(samp[0]), .oError(err[0]), .bus(ifc0.master)
    );

    neuron_train_sequencer #(.NB(3), .NS(4), .TIMEOUT(8)) dut1 (
        .iCLK(clk), .iRST(rst), .iStart(start[1]), .iTrain(train[1]),
        .oBusy(busy[1]), .oDone(done[1]), .oMode(mode[1]), .oUpdate(upd[1]),
        .oSample(samp[1]), .oError(err[1]), .bus(ifc1.master)
    );

    int tok_samp [$];
    int tok_mode [$];
    int upd_samp [$];
    int upd_cycles;
    int done_cnt;
    bit epoch_ok;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q [$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Start an epoch on sequencer s and run it to oDone with an always-ready environment
    task automatic run_epoch(input int s, input bit tr);
        int cnt;
        tok_samp.delete();
        tok_mode.delete();
        upd_samp.delete();
        upd_cycles = 0;
        done_cnt   = 0;
        epoch_ok   = 1'b0;
        vfwd[s] = 1'b1; rbfwd[s] = 1'b1; vbwd[s] = 1'b1; rbbwd[s] = 1'b1;
        vcmp[s] = 1'b0; rcmp[s] = 1'b0;
        train[s] = tr;
        start[s] = 1'b1;
        tick();
        start[s] = 1'b0;
        cnt = 0;
        for (int cyc = 0; cyc < 400 && !epoch_ok; cyc++) begin
            vcmp[s] = (cnt == 1);
            rcmp[s] = (cnt == 1);
            if (cnt > 0) cnt--;
            #1;
            if (ovf[s]) begin
                tok_samp.push_back(int'(samp[s]));
                tok_mode.push_back(int'(mode[s]));
                cnt = 3;
            end
            if (ovb[s]) begin
                tok_samp.push_back(int'(samp[s]));
                tok_mode.push_back(int'(mode[s]));
                cnt = 3;
            end
            if (upd[s]) begin
                upd_samp.push_back(int'(samp[s]));
                upd_cycles++;
            end
            if (done[s]) begin
                done_cnt++;
                epoch_ok = 1'b1;
            end
            tick();
        end
        vcmp[s] = 1'b0; rcmp[s] = 1'b0;
        vfwd[s] = 1'b0; vbwd[s] = 1'b0;
        chk("epoch_reached_done", epoch_ok, 1);
        chk("done_one_cycle", done[s], 0);
        chk("idle_after_done", busy[s], 0);
    endtask

    int exp_tr_samp [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    int exp_tr_mode [8] = '{0, 1, 0, 1, 0, 1, 0, 1};

    initial begin
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; train[k] = 1'b0;
            vfwd[k] = 1'b0; rbfwd[k] = 1'b0; vbwd[k] = 1'b0; rbbwd[k] = 1'b0;
            vcmp[k] = 1'b0; rcmp[k] = 1'b0;
        end

        // Reset then idle
        rst = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy[0], 0);
        chk("rst_done", done[0], 0);
        chk("rst_mode", mode[0], 0);
        chk("rst_update", upd[0], 0);
        chk("rst_error", err[0], 0);
        chk("rst_sample", samp[0], 0);
        rst = 1'b1;
        tick();
        vfwd[0] = 1'b1; rbfwd[0] = 1'b1;
        #1;
        chk("idle_fwd_valid_closed", ovf[0], 0);
        chk("idle_fwd_ready_closed", oraf[0], 0);
        vfwd[0] = 1'b0; rbfwd[0] = 1'b0;
        tick();

        // Training NB=2 NS=4
        run_epoch(0, 1'b1);
        chk("tr_tok_count", tok_samp.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tr_tok%0d_sample", i), qget(tok_samp, i), exp_tr_samp[i]);
            chk($sformatf("tr_tok%0d_mode", i), qget(tok_mode, i), exp_tr_mode[i]);
        end
        chk("tr_upd_pulses", upd_samp.size(), 2);
        chk("tr_upd0_sample", qget(upd_samp, 0), 1);
        chk("tr_upd1_sample", qget(upd_samp, 1), 3);
        chk("tr_upd_width", upd_cycles, 2);
        chk("tr_done_count", done_cnt, 1);

        // Partial final batch NB=3 NS=4
        run_epoch(1, 1'b1);
        chk("pb_tok_count", tok_samp.size(), 8);
        chk("pb_upd_pulses", upd_samp.size(), 2);
        chk("pb_upd0_sample", qget(upd_samp, 0), 2);
        chk("pb_upd1_sample", qget(upd_samp, 1), 3);
        chk("pb_done_count", done_cnt, 1);

        // Inference NS=4
        run_epoch(0, 1'b0);
        chk("inf_tok_count", tok_samp.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("inf_tok%0d_sample", i), qget(tok_samp, i), i);
            chk($sformatf("inf_tok%0d_mode", i), qget(tok_mode, i), 0);
        end
        chk("inf_upd_pulses", upd_cycles, 0);
        chk("inf_done_count", done_cnt, 1);

        // Backpressure in FWD with stray completions, then reset in BWD_WAIT
        train[0] = 1'b1; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        vfwd[0] = 1'b1; rbfwd[0] = 1'b0; vcmp[0] = 1'b1; rcmp[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp%0d_fwd_valid_held", i), ovf[0], 1);
            chk($sformatf("bp%0d_fwd_ready_low", i), oraf[0], 0);
            chk($sformatf("bp%0d_mode", i), mode[0], 0);
        end
        vcmp[0] = 1'b0; rcmp[0] = 1'b0; rbfwd[0] = 1'b1;
        tick();
        chk("bp_fwdwait_gate_closed", ovf[0], 0);
        chk("bp_fwdwait_mode", mode[0], 0);
        vfwd[0] = 1'b0;
        vcmp[0] = 1'b1; rcmp[0] = 1'b1;
        tick();
        vcmp[0] = 1'b0; rcmp[0] = 1'b0;
        vbwd[0] = 1'b1; rbbwd[0] = 1'b1;
        #1;
        chk("bp_bwd_mode", mode[0], 1);
        chk("bp_bwd_gate_open", ovb[0], 1);
        tick();
        vbwd[0] = 1'b0;
        chk("bp_bwdwait_mode", mode[0], 1);
        chk("bp_bwdwait_gate_closed", orab[0], 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("abort_busy", busy[0], 0);
        chk("abort_mode", mode[0], 0);
        chk("abort_update", upd[0], 0);
        chk("abort_done", done[0], 0);
        tick();
        chk("abort_no_update_after", upd[0], 0);
        chk("abort_no_done_after", done[0], 0);

        // Watchdog on FWD_WAIT with no completion
        train[0] = 1'b1; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        vfwd[0] = 1'b1; rbfwd[0] = 1'b1;
        tick();
        vfwd[0] = 1'b0;
        chk("wd_in_wait", busy[0], 1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("wd_cycle%0d_error", i), err[0], 0);
        end
        tick();
`ifdef SEQ_TIMEOUT_EN
        chk("wd_error_raised", err[0], 1);
        chk("wd_forced_idle", busy[0], 0);
        chk("wd_no_done", done[0], 0);
        tick();
        tick();
        tick();
        chk("wd_error_sticky", err[0], 1);
`else
        chk("wd_disabled_no_error", err[0], 0);
        chk("wd_disabled_still_waiting", busy[0], 1);
`endif
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("wd_reset_clears_error", err[0], 0);
        chk("wd_reset_idle", busy[0], 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neuron_train_sequencer.md
# neuron_train_sequencer

Controls one Neuron layer during training and inference. It drives the layer's mode bit and admits exactly one forward token, then one backward token, per sample. It counts samples into mini-batches and issues a weight-update strobe at each batch boundary. It sits between the network input/error streams and the Neuron's accumulator input, and observes the Neuron's output handshake as the completion signal.

## Interface
- NB, 4: samples per mini-batch (>=1).
- NS, 16: samples per epoch (>=1; need not be a multiple of NB).
- TIMEOUT, 255: wait-state watchdog limit in cycles (used only with SEQ_TIMEOUT_EN).

- iCLK  in  1  clock; all logic on rising edge.
- iRST  in  1  synchronous, active-low reset.
- iStart  in  1  start epoch; sampled in IDLE only.
- iTrain  in  1  1 = training epoch, 0 = inference; latched at start.
- oBusy  out  1  high in every state except IDLE.
- oDone  out  1  one-cycle pulse at end of epoch.
- oMode  out  1  to Neuron iMode; 0 = forward, 1 = backward.
- oUpdate  out  1  one-cycle weight-update strobe.
- oSample  out  max(1,$clog2(NS))  index of the current sample.
- oError  out  1  sticky timeout flag (tied 0 without SEQ_TIMEOUT_EN).
- iValid_AM_Fwd / oReady_AM_Fwd  in/out  1  upstream forward-token handshake.
- oValid_BM_Fwd / iReady_BM_Fwd  out/in  1  forward token to the Neuron.
- iValid_AM_Bwd / oReady_AM_Bwd  in/out  1  upstream backward-token (error) handshake.
- oValid_BM_Bwd / iReady_BM_Bwd  out/in  1  backward token to the Neuron.
- iValid_Cmp, iReady_Cmp  in  1  observed Neuron output handshake; completion = both high.

## Operation
- States: IDLE, FWD, FWD_WAIT, BWD, BWD_WAIT, UPDATE, DONE. The state, counters, oMode, oUpdate, oDone and oError are registers.
- IDLE:
  - All gates are closed.
  - iStart=1 clears the sample and batch counters, latches iTrain, and moves to FWD.
- FWD:
  - The forward gate is open: oValid_BM_Fwd=iValid_AM_Fwd and oReady_AM_Fwd=iReady_BM_Fwd (combinational).
  - A forward handshake moves to FWD_WAIT.
- FWD_WAIT:
  - Gates are closed.
  - On completion: if training, go to BWD. If inference, go to DONE when the sample index is NS-1; otherwise increment the sample counter and go to FWD.
- BWD:
  - oMode=1 and the backward gate is open (same pass-through rule as FWD).
  - A backward handshake moves to BWD_WAIT.
- BWD_WAIT:
  - oMode=1.
  - On completion, if the batch count is NB-1 or the sample index is NS-1, go to UPDATE.
  - Otherwise increment both counters and go to FWD.
- UPDATE:
  - oUpdate=1 for this single cycle and the batch counter clears.
  - If the sample index is NS-1, go to DONE; otherwise increment the sample counter and go to FWD.
- DONE: oDone=1 for one cycle, then IDLE.
- oMode is 1 only in BWD and BWD_WAIT. It changes only on entering or leaving those states, so it never changes while a gate is open.
- Closed gate: oValid_BM_* = 0 and oReady_AM_* = 0.
- Completion handshakes outside the WAIT states are ignored.
- Counters saturate nowhere; they wrap only by explicit clear.
- A final partial batch (NS not a multiple of NB) still produces an update.

## Timing
- Reset (iRST=0 at an edge) puts the block in IDLE with oMode=0, oUpdate=0, oDone=0, oError=0, oSample=0 and oBusy=0. All gates close that cycle.
- Reset mid-operation aborts immediately; no update or done pulse is emitted.
- iStart seen at edge t puts the block in FWD at t+1. iStart while busy is ignored.
- A token handshake at edge t puts the block in the WAIT state at t+1.
- A completion at edge t gives the next state at t+1.
- Minimum per training sample with zero stalls: 4 cycles, plus 1 on batch boundaries.
- Minimum per inference sample: 2 cycles.
- oUpdate and oDone are each exactly one cycle wide.

## Configuration
- SEQ_TIMEOUT_EN defined:
  - A counter clears on entry to FWD_WAIT or BWD_WAIT and counts each cycle spent waiting.
  - Reaching TIMEOUT sets oError (sticky until reset) and forces IDLE without a done pulse.
  - A completion in the same cycle that TIMEOUT is reached wins: no error is flagged.
- Undefined: no counter exists, oError is constant 0, and the WAIT states wait indefinitely.

## Test plan
- Reset then idle: iRST=0 for 2 cycles -> all outputs 0. iValid_AM_Fwd=1 in IDLE -> oValid_BM_Fwd=0 and oReady_AM_Fwd=0.
- Training, NB=2, NS=4, zero stalls, completion 3 cycles after each token:
  - Sample sequence is 0,0,1,1,2,2,3,3 (fwd then bwd for each sample); oMode high only during bwd phases.
  - Exactly 2 oUpdate pulses, after samples 1 and 3, then one oDone.
- Partial batch, NB=3, NS=4 -> oUpdate after samples 2 and 3 (2 pulses total).
- Inference, iTrain=0, NS=4 -> 4 forward tokens, oMode constant 0, no oUpdate, oDone once.
- Backpressure: iReady_BM_Fwd=0 for 5 cycles in FWD:
  - State holds and oReady_AM_Fwd=0.
  - Stray completions during FWD are ignored.
  - iRST=0 asserted in BWD_WAIT -> IDLE next cycle, no pulses.
- SEQ_TIMEOUT_EN, TIMEOUT=8, no completion -> oError rises 8 cycles after entering FWD_WAIT, state IDLE, oError persists until reset.
